// File: rtl/nonce_result_scanner_pkg.sv
// Shared types for the nonce result scanner: FSM encodings and the per-word compare result.
package nonce_result_scanner_pkg;

    localparam int unsigned NumNoncesDef = 16;
    localparam int unsigned NonceMaxW    = 16;

    typedef logic [2:0] state_t;

    localparam state_t StIdle     = 3'd0;
    localparam state_t StStart    = 3'd1;
    localparam state_t StWaitLow  = 3'd2;
    localparam state_t StWaitHigh = 3'd3;
    localparam state_t StRead     = 3'd4;
    localparam state_t StDrain    = 3'd5;
    localparam state_t StReport   = 3'd6;

    // Nonce field sized for the widest index the 16-bit word address space allows.
    typedef struct packed {
        logic                 hit;
        logic [31:0]          h0;
        logic [NonceMaxW-1:0] nonce;
    } h0_cmp_t;

endpackage

// File: rtl/nonce_result_scanner_if.sv
// Host command, hash-core handshake, result-memory read port and result bundle of the scanner.
interface nonce_result_scanner_if
    import nonce_result_scanner_pkg::*;
#(
    parameter int unsigned NUM_NONCES = NumNoncesDef,
    parameter int unsigned NONCE_W    = $clog2(NUM_NONCES)
);
    logic                  go;
    logic [15:0]           out_addr;
    logic [31:0]           target;
    logic                  hash_start;
    logic                  hash_done;
    logic                  rd_en;
    logic [15:0]           rd_addr;
    logic [31:0]           rd_data;
    logic                  busy;
    logic                  valid;
    logic                  err;
    logic                  found;
    logic [NUM_NONCES-1:0] hit_mask;
    logic [NONCE_W-1:0]    best_nonce;
    logic [31:0]           best_h0;

    // Environment side: host, hash core and memory.
    modport master (
        output go, out_addr, target, hash_done, rd_data,
        input  hash_start, rd_en, rd_addr, busy, valid, err, found, hit_mask, best_nonce, best_h0
    );

    // Scanner side.
    modport slave (
        input  go, out_addr, target, hash_done, rd_data,
        output hash_start, rd_en, rd_addr, busy, valid, err, found, hit_mask, best_nonce, best_h0
    );

endinterface

// File: rtl/nonce_result_scanner_min_tracker.sv
// Registered running minimum of H0 with its nonce; strict-less update so ties keep the earlier nonce.
module nonce_result_scanner_min_tracker
    import nonce_result_scanner_pkg::*;
#(
    parameter int unsigned NONCE_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr_i,
    input  logic               upd_i,
    input  h0_cmp_t            cmp_i,
    output logic [31:0]        best_h0_o,
    output logic [NONCE_W-1:0] best_nonce_o
);
    logic [31:0]        best_h0_q;
    logic [NONCE_W-1:0] best_nonce_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_h0_q    <= 32'hFFFF_FFFF;
            best_nonce_q <= '0;
        end else if (clr_i) begin
            best_h0_q    <= 32'hFFFF_FFFF;
            best_nonce_q <= '0;
        end else if (upd_i && (cmp_i.h0 < best_h0_q)) begin
            best_h0_q    <= cmp_i.h0;
            best_nonce_q <= cmp_i.nonce[NONCE_W-1:0];
        end
    end

    // The hit flag and the index bits above NONCE_W are not needed here.
    logic unused_cmp;
    if (NONCE_W < NonceMaxW) begin : g_narrow
        assign unused_cmp = cmp_i.hit ^ (^cmp_i.nonce[NonceMaxW-1:NONCE_W]);
    end else begin : g_full
        assign unused_cmp = cmp_i.hit;
    end

    assign best_h0_o    = best_h0_q;
    assign best_nonce_o = best_nonce_q;

endmodule

// File: rtl/nonce_result_scanner.sv
// Launches one hash run, waits out the done handshake, then scans the H0 words for minimum and hits.
module nonce_result_scanner
    import nonce_result_scanner_pkg::*;
#(
    parameter int unsigned NUM_NONCES     = NumNoncesDef,
    parameter int unsigned NONCE_W        = $clog2(NUM_NONCES),
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nonce_result_scanner_if.slave bus_io
);
    localparam int unsigned        TimerW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0]  TimerMax = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [NONCE_W-1:0] IdxLast  = NONCE_W'(NUM_NONCES - 1);

    state_t                state_q, state_d;
    logic [TimerW-1:0]     timer_q, timer_d;
    logic [15:0]           out_addr_q, out_addr_d;
    logic [31:0]           target_q, target_d;
    logic [15:0]           rd_addr_q, rd_addr_d;
    logic [NONCE_W-1:0]    rd_idx_q, rd_idx_d;
    logic                  err_q, err_d;
    logic [NUM_NONCES-1:0] hit_mask_q, hit_mask_d;
    logic                  cmp_vld_q;
    logic [NONCE_W-1:0]    cmp_idx_q;
    logic                  start_run;
    h0_cmp_t               cmp;

    assign start_run = (state_q == StIdle) && bus_io.go;

    // Compare stage: rd_data belongs to the read issued one cycle earlier.
    assign cmp = '{hit: (bus_io.rd_data < target_q), h0: bus_io.rd_data,
                   nonce: NonceMaxW'(cmp_idx_q)};

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        out_addr_d = out_addr_q;
        target_d   = target_q;
        rd_addr_d  = rd_addr_q;
        rd_idx_d   = rd_idx_q;
        err_d      = err_q;
        hit_mask_d = hit_mask_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.go) begin
                    out_addr_d = bus_io.out_addr;
                    target_d   = bus_io.target;
                    hit_mask_d = '0;
                    err_d      = 1'b0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                timer_d = '0;
                state_d = StWaitLow;
            end
            StWaitLow: begin
                if (!bus_io.hash_done) begin
                    timer_d = '0;
                    state_d = StWaitHigh;
                end else if (timer_q == TimerMax) begin
                    err_d   = 1'b1;
                    state_d = StReport;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitHigh: begin
                if (bus_io.hash_done) begin
                    rd_idx_d  = '0;
                    rd_addr_d = out_addr_q;
                    state_d   = StRead;
                end else if (timer_q == TimerMax) begin
                    err_d   = 1'b1;
                    state_d = StReport;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRead: begin
                if (rd_idx_q == IdxLast) begin
                    state_d = StDrain;
                end else begin
                    rd_idx_d  = rd_idx_q + 1'b1;
                    rd_addr_d = rd_addr_q + 16'd1;
                end
            end
            StDrain:  state_d = StReport;
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (cmp_vld_q) begin
            hit_mask_d[cmp_idx_q] = cmp.hit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            out_addr_q <= '0;
            target_q   <= '0;
            rd_addr_q  <= '0;
            rd_idx_q   <= '0;
            err_q      <= 1'b0;
            hit_mask_q <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            out_addr_q <= out_addr_d;
            target_q   <= target_d;
            rd_addr_q  <= rd_addr_d;
            rd_idx_q   <= rd_idx_d;
            err_q      <= err_d;
            hit_mask_q <= hit_mask_d;
            cmp_vld_q  <= (state_q == StRead);
            cmp_idx_q  <= rd_idx_q;
        end
    end

    nonce_result_scanner_min_tracker #(
        .NONCE_W (NONCE_W)
    ) u_min_tracker (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_i        (start_run),
        .upd_i        (cmp_vld_q),
        .cmp_i        (cmp),
        .best_h0_o    (bus_io.best_h0),
        .best_nonce_o (bus_io.best_nonce)
    );

    assign bus_io.hash_start = (state_q == StStart);
    assign bus_io.rd_en      = (state_q == StRead);
    assign bus_io.rd_addr    = rd_addr_q;
    assign bus_io.busy       = (state_q != StIdle);
    assign bus_io.valid      = (state_q == StReport);
    assign bus_io.err        = err_q;
    assign bus_io.found      = |hit_mask_q;
    assign bus_io.hit_mask   = hit_mask_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Scoreboard bench for nonce_result_scanner: directed runs with hand-computed results.
module tb_nonce_result_scanner;

    localparam int unsigned N  = 16;
    localparam int unsigned TO = 4096;

    typedef struct {
        logic        err;
        logic        found;
        logic [15:0] hit;
        logic [3:0]  nonce;
        logic [31:0] h0;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nonce_result_scanner_if #(.NUM_NONCES(N)) bus ();

    nonce_result_scanner #(
        .NUM_NONCES     (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus)
    );

    logic [31:0] mem [0:65535];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int valids = 0;
    exp_t exp_q[$];
    logic [15:0] exp_addr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a read or a result.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.hash_start) starts++;
            if (bus.rd_en) begin
                if (exp_addr_q.size() == 0) check("unexpected_read", {16'h0, bus.rd_addr}, 32'hDEAD);
                else check("rd_addr", {16'h0, bus.rd_addr}, {16'h0, exp_addr_q.pop_front()});
            end
            if (bus.valid) begin
                valids++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("err", {31'h0, bus.err}, {31'h0, e.err});
                    check("found", {31'h0, bus.found}, {31'h0, e.found});
                    check("hit_mask", {16'h0, bus.hit_mask}, {16'h0, e.hit});
                    check("best_nonce", {28'h0, bus.best_nonce}, {28'h0, e.nonce});
                    check("best_h0", bus.best_h0, e.h0);
                end
            end
        end
    end

    task automatic push_exp(input logic err, input logic found, input logic [15:0] hit,
                            input logic [3:0] nonce, input logic [31:0] h0);
        exp_t e;
        e = '{err: err, found: found, hit: hit, nonce: nonce, h0: h0};
        exp_q.push_back(e);
    endtask

    task automatic expect_reads(input logic [15:0] base, input int cnt);
        logic [15:0] a;
        a = base;
        for (int i = 0; i < cnt; i++) begin
            exp_addr_q.push_back(a);
            a = a + 16'd1;
        end
    endtask

    task automatic pulse_go(input logic [15:0] a, input logic [31:0] t);
        bus.out_addr = a;
        bus.target   = t;
        bus.go       = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic wait_start();
        int c;
        c = 0;
        while (!bus.hash_start && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (!bus.hash_start) check("hash_start_seen", 32'd0, 32'd1);
    endtask

    task automatic core(input int lo, input int hi);
        repeat (lo) @(negedge clk);
        bus.hash_done = 1'b0;
        repeat (hi) @(negedge clk);
        bus.hash_done = 1'b1;
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        while (!bus.valid && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.valid) check("valid_seen", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, cyc, c;
        logic [15:0] a;
        reset_n       = 1'b0;
        bus.go        = 1'b0;
        bus.out_addr  = '0;
        bus.target    = '0;
        bus.hash_done = 1'b1;
        for (int n = 0; n < N; n++) begin
            mem[16'h0100 + 16'(n)] = 32'h1000_0000 + n;
            mem[16'h0200 + 16'(n)] = 32'hFFFF_0000;
            mem[16'h0300 + 16'(n)] = n;
        end
        mem[16'h0209] = 32'h0000_0042;
        mem[16'h020C] = 32'h0000_0042;
        a = 16'hFFF8;
        for (int n = 0; n < N; n++) begin
            mem[a] = 32'h0000_1000 - n;
            a = a + 16'd1;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'd0);
        check("rst_valid", {31'h0, bus.valid}, 32'd0);
        check("rst_rd_en", {31'h0, bus.rd_en}, 32'd0);
        check("rst_hash_start", {31'h0, bus.hash_start}, 32'd0);
        check("rst_best_h0", bus.best_h0, 32'hFFFF_FFFF);
        check("rst_hit_mask", {16'h0, bus.hit_mask}, 32'd0);
        check("rst_rd_addr", {16'h0, bus.rd_addr}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal run.
        expect_reads(16'h0100, N);
        push_exp(1'b0, 1'b1, 16'h00FF, 4'd0, 32'h1000_0000);
        s0 = starts;
        pulse_go(16'h0100, 32'h1000_0008);
        wait_start();
        core(5, 200);
        wait_valid(100, cyc);
        check("read_latency", cyc, N + 2);
        @(negedge clk);
        check("nom_starts", starts - s0, 32'd1);

        // Tie at the minimum, target equal to the minimum.
        expect_reads(16'h0200, N);
        push_exp(1'b0, 1'b0, 16'h0000, 4'd9, 32'h0000_0042);
        pulse_go(16'h0200, 32'h0000_0042);
        wait_start();
        core(3, 10);
        wait_valid(100, cyc);
        @(negedge clk);

        // Address wrap.
        expect_reads(16'hFFF8, N);
        push_exp(1'b0, 1'b1, 16'hFE00, 4'd15, 32'h0000_0FF1);
        pulse_go(16'hFFF8, 32'h0000_0FF8);
        wait_start();
        core(2, 7);
        wait_valid(100, cyc);
        @(negedge clk);

        // Timeout: done never drops.
        push_exp(1'b1, 1'b0, 16'h0000, 4'd0, 32'hFFFF_FFFF);
        pulse_go(16'h0100, 32'h1000_0008);
        wait_start();
        wait_valid(TO + 50, cyc);
        check("timeout_cycles", cyc, TO + 1);
        @(negedge clk);

        // Go while busy is ignored, then reset mid-read.
        expect_reads(16'h0300, 6);
        s0 = starts;
        c  = valids;
        pulse_go(16'h0300, 32'h0000_0008);
        wait_start();
        repeat (2) @(negedge clk);
        pulse_go(16'h0300, 32'h0000_0008);
        core(2, 20);
        cyc = 0;
        while (!(bus.rd_en && bus.rd_addr == 16'h0305) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_idx5", {16'h0, bus.rd_addr}, 32'h0305);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, bus.busy}, 32'd0);
        check("mid_rst_rd_en", {31'h0, bus.rd_en}, 32'd0);
        check("mid_rst_best_h0", bus.best_h0, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("busy_go_starts", starts - s0, 32'd1);
        check("no_valid_after_rst", valids - c, 32'd0);
        check("reads_consumed", exp_addr_q.size(), 32'd0);

        // Back-to-back runs, second go the cycle after valid.
        s0 = starts;
        expect_reads(16'h0100, N);
        push_exp(1'b0, 1'b1, 16'h00FF, 4'd0, 32'h1000_0000);
        pulse_go(16'h0100, 32'h1000_0008);
        wait_start();
        core(5, 30);
        wait_valid(100, cyc);
        @(negedge clk);
        expect_reads(16'h0200, N);
        push_exp(1'b0, 1'b0, 16'h0000, 4'd9, 32'h0000_0042);
        pulse_go(16'h0200, 32'h0000_0000);
        wait_start();
        core(4, 12);
        wait_valid(100, cyc);
        @(negedge clk);
        check("b2b_starts", starts - s0, 32'd2);

        repeat (5) @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
